axil_arb_2m: RTL and testbench

AXIL_ARB_2M -- requirements
Module: axil_arb_2m

---
 rtl/axil_arb_2m.sv | 194 +++++++++++++++++++
 tb/tb_axil_arb_2m.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_arb_2m.sv
// Two-requester AXI4-Lite arbiter onto one shared MMIO master port.
// Independent write and read arbiters, each round-robin or fixed priority.
module axil_arb_2m #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        nrst,
  // requester 0
  input  logic [31:0] m0_awaddr,
  input  logic [2:0]  m0_awprot,
  input  logic        m0_awvalid,
  output logic        m0_awready,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  input  logic        m0_wvalid,
  output logic        m0_wready,
  output logic [1:0]  m0_bresp,
  output logic        m0_bvalid,
  input  logic        m0_bready,
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arprot,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  // requester 1
  input  logic [31:0] m1_awaddr,
  input  logic [2:0]  m1_awprot,
  input  logic        m1_awvalid,
  output logic        m1_awready,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_wvalid,
  output logic        m1_wready,
  output logic [1:0]  m1_bresp,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arprot,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  // shared master port toward MMIO
  output logic [31:0] s_awaddr,
  output logic [2:0]  s_awprot,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arprot,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  // arbiter state: 0 IDLE, 1 GNT0, 2 GNT1
  output logic [1:0]  wr_state,
  output logic [1:0]  rd_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both high; valid never waits on ready.

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_t;

  arb_state_t w_st, r_st;
  logic       w_last, r_last;  // 1 = M1 served last
  logic       aw_done, w_done, ar_done;

  logic w_g0, w_g1, r_g0, r_g1;
  logic w_req0, w_req1;

  // Ties go to whoever was not served last (RR) or always to M0 (fixed).
  function automatic arb_state_t pick(input logic req0, input logic req1,
                                      input logic last);
    if (req0 && req1)
      return (RR_EN && !last) ? GNT1 : GNT0;
    else if (req1)
      return GNT1;
    else if (req0)
      return GNT0;
    else
      return IDLE;
  endfunction

  assign w_req0 = m0_awvalid | m0_wvalid;
  assign w_req1 = m1_awvalid | m1_wvalid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_st    <= IDLE;
      w_last  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_st)
        IDLE: begin
          w_st    <= pick(w_req0, w_req1, w_last);
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        GNT0, GNT1: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready)   w_done  <= 1'b1;
          if (s_bvalid && s_bready) begin
            w_st    <= IDLE;
            w_last  <= (w_st == GNT1);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: w_st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_st    <= IDLE;
      r_last  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      case (r_st)
        IDLE: begin
          r_st    <= pick(m0_arvalid, m1_arvalid, r_last);
          ar_done <= 1'b0;
        end
        GNT0, GNT1: begin
          if (s_arvalid && s_arready) ar_done <= 1'b1;
          if (s_rvalid && s_rready) begin
            r_st    <= IDLE;
            r_last  <= (r_st == GNT1);
            ar_done <= 1'b0;
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  assign w_g0 = (w_st == GNT0);
  assign w_g1 = (w_st == GNT1);
  assign r_g0 = (r_st == GNT0);
  assign r_g1 = (r_st == GNT1);

  assign wr_state = w_st;
  assign rd_state = r_st;

  // Write path: payload muxed by grant, valids masked once their beat is taken.
  assign s_awaddr  = w_g1 ? m1_awaddr : m0_awaddr;
  assign s_awprot  = w_g1 ? m1_awprot : m0_awprot;
  assign s_wdata   = w_g1 ? m1_wdata  : m0_wdata;
  assign s_wstrb   = w_g1 ? m1_wstrb  : m0_wstrb;
  assign s_awvalid = ((w_g0 & m0_awvalid) | (w_g1 & m1_awvalid)) & ~aw_done;
  assign s_wvalid  = ((w_g0 & m0_wvalid)  | (w_g1 & m1_wvalid))  & ~w_done;
  assign s_bready  = (w_g0 & m0_bready) | (w_g1 & m1_bready);

  assign m0_awready = w_g0 & s_awready & ~aw_done;
  assign m1_awready = w_g1 & s_awready & ~aw_done;
  assign m0_wready  = w_g0 & s_wready & ~w_done;
  assign m1_wready  = w_g1 & s_wready & ~w_done;
  assign m0_bvalid  = w_g0 & s_bvalid;
  assign m1_bvalid  = w_g1 & s_bvalid;
  assign m0_bresp   = s_bresp;
  assign m1_bresp   = s_bresp;

  // Read path mirrors the write path with a single address mask.
  assign s_araddr  = r_g1 ? m1_araddr : m0_araddr;
  assign s_arprot  = r_g1 ? m1_arprot : m0_arprot;
  assign s_arvalid = ((r_g0 & m0_arvalid) | (r_g1 & m1_arvalid)) & ~ar_done;
  assign s_rready  = (r_g0 & m0_rready) | (r_g1 & m1_rready);

  assign m0_arready = r_g0 & s_arready & ~ar_done;
  assign m1_arready = r_g1 & s_arready & ~ar_done;
  assign m0_rvalid  = r_g0 & s_rvalid;
  assign m1_rvalid  = r_g1 & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;

endmodule

// File: tb/tb_axil_arb_2m.sv
// Directed bench for axil_arb_2m: a round-robin instance under full check and
// a fixed-priority instance sharing its inputs for the tie-break case.
module tb_axil_arb_2m;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // shared inputs
  logic [31:0] m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, m0_araddr, m1_araddr;
  logic [2:0]  m0_awprot, m1_awprot, m0_arprot, m1_arprot;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid, m0_arvalid, m1_arvalid;
  logic        m0_bready, m1_bready, m0_rready, m1_rready;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  // round-robin instance outputs
  logic        m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid;
  logic [1:0]  m0_bresp, m1_bresp, m0_rresp, m1_rresp;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [1:0]  wr_state, rd_state;

  // fixed-priority instance outputs
  logic        f_m0_awready, f_m1_awready, f_m0_wready, f_m1_wready, f_m0_bvalid, f_m1_bvalid;
  logic        f_m0_arready, f_m1_arready, f_m0_rvalid, f_m1_rvalid;
  logic [1:0]  f_m0_bresp, f_m1_bresp, f_m0_rresp, f_m1_rresp;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic [31:0] f_s_awaddr, f_s_wdata, f_s_araddr;
  logic [2:0]  f_s_awprot, f_s_arprot;
  logic [3:0]  f_s_wstrb;
  logic        f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready;
  logic [1:0]  f_wr_state, f_rd_state;

  axil_arb_2m #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .nrst(nrst),
    .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_state(wr_state), .rd_state(rd_state)
  );

  axil_arb_2m #(.RR_EN(1'b0)) u_fx (
    .clk(clk), .nrst(nrst),
    .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awvalid(m0_awvalid), .m0_awready(f_m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(f_m0_wready),
    .m0_bresp(f_m0_bresp), .m0_bvalid(f_m0_bvalid), .m0_bready(m0_bready),
    .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
    .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awvalid(m1_awvalid), .m1_awready(f_m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(f_m1_wready),
    .m1_bresp(f_m1_bresp), .m1_bvalid(f_m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
    .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(f_s_awaddr), .s_awprot(f_s_awprot), .s_awvalid(f_s_awvalid), .s_awready(s_awready),
    .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wvalid(f_s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(f_s_bready),
    .s_araddr(f_s_araddr), .s_arprot(f_s_arprot), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(f_s_rready),
    .wr_state(f_wr_state), .rd_state(f_rd_state)
  );

  int vectors = 0;
  int miscompares = 0;
  int aw_hs = 0;
  int w_hs = 0;
  int aw0, w0;

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_r0_q[$];
  logic [31:0] exp_r1_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_awaddr = '0; m0_awprot = '0; m0_awvalid = 0; m0_wdata = '0; m0_wstrb = '0; m0_wvalid = 0;
    m0_bready = 0; m0_araddr = '0; m0_arprot = '0; m0_arvalid = 0; m0_rready = 0;
    m1_awaddr = '0; m1_awprot = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 0;
    m1_bready = 0; m1_araddr = '0; m1_arprot = '0; m1_arvalid = 0; m1_rready = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_arready = 0;
    s_rvalid = 0; s_rdata = '0; s_rresp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  // Scoreboard: s-side address/data beats and m-side read data are popped here.
  always @(negedge clk) begin
    if (nrst) begin
      if (s_awvalid && s_awready) begin
        aw_hs++;
        if (exp_aw_q.size() == 0) chk("aw_extra", 32'(exp_aw_q.size()), 32'd1);
        else chk("aw_addr", s_awaddr, exp_aw_q.pop_front());
      end
      if (s_wvalid && s_wready) begin
        w_hs++;
        if (exp_w_q.size() == 0) chk("w_extra", 32'(exp_w_q.size()), 32'd1);
        else chk("w_data", s_wdata, exp_w_q.pop_front());
      end
      if (s_arvalid && s_arready) begin
        if (exp_ar_q.size() == 0) chk("ar_extra", 32'(exp_ar_q.size()), 32'd1);
        else chk("ar_addr", s_araddr, exp_ar_q.pop_front());
      end
      if (m0_rvalid && m0_rready) begin
        if (exp_r0_q.size() == 0) chk("r0_extra", 32'(exp_r0_q.size()), 32'd1);
        else chk("m0_rdata", m0_rdata, exp_r0_q.pop_front());
      end
      if (m1_rvalid && m1_rready) begin
        if (exp_r1_q.size() == 0) chk("r1_extra", 32'(exp_r1_q.size()), 32'd1);
        else chk("m1_rdata", m1_rdata, exp_r1_q.pop_front());
      end
    end
  end

  initial begin
    // reset with requests and slave activity present: everything stays gated
    idle_inputs();
    nrst = 1'b0;
    m0_awvalid = 1; m1_arvalid = 1; m0_bready = 1; m1_rready = 1;
    s_awready = 1; s_bvalid = 1; s_rvalid = 1; s_arready = 1;
    tick();
    chk("rst_s_valids", 32'({s_awvalid, s_wvalid, s_arvalid}), 32'd0);
    chk("rst_s_readies", 32'({s_bready, s_rready}), 32'd0);
    chk("rst_m_hs", 32'({m0_awready, m0_bvalid, m1_arready, m1_rvalid}), 32'd0);
    chk("rst_states", 32'({wr_state, rd_state}), 32'd0);
    idle_inputs();
    nrst = 1'b1;
    tick();
    chk("post_rst_outs", 32'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 32'd0);

    // single M0 write, AW and W together
    m0_awaddr = 32'h0000_0010; m0_awprot = 3'b010; m0_awvalid = 1;
    m0_wdata = 32'hA5A5_A5A5; m0_wstrb = 4'hF; m0_wvalid = 1;
    exp_aw_q.push_back(32'h0000_0010); exp_w_q.push_back(32'hA5A5_A5A5);
    #1;
    chk("t1_idle_no_fwd", 32'({s_awvalid, s_wvalid}), 32'd0);
    tick();
    chk("t1_gnt0", 32'(wr_state), 32'd1);
    chk("t1_s_valids", 32'({s_awvalid, s_wvalid}), 32'b11);
    chk("t1_awprot", 32'(s_awprot), 32'd2);
    s_awready = 1; s_wready = 1;
    #1;
    chk("t1_readies", 32'({m0_awready, m0_wready, m1_awready, m1_wready}), 32'b1100);
    tick();
    m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1; s_bresp = 2'b00; m0_bready = 1;
    #1;
    chk("t1_bvalid", 32'({m0_bvalid, m1_bvalid, s_bready}), 32'b101);
    chk("t1_bresp", 32'(m0_bresp), 32'd0);
    tick();
    s_bvalid = 0; m0_bready = 0;
    #1;
    chk("t1_back_idle", 32'(wr_state), 32'd0);

    // simultaneous reads from reset: RR gives M1 first, fixed gives M0
    do_reset();
    m0_araddr = 32'h0000_0200; m1_araddr = 32'h0000_0300;
    m0_arvalid = 1; m1_arvalid = 1;
    exp_ar_q.push_back(32'h0000_0300); exp_ar_q.push_back(32'h0000_0200);
    #1;
    chk("t2_idle_no_fwd", 32'(s_arvalid), 32'd0);
    tick();
    chk("t2_rr_gnt1", 32'(rd_state), 32'd2);
    chk("t2_fx_gnt0", 32'(f_rd_state), 32'd1);
    chk("t2_fx_araddr", f_s_araddr, 32'h0000_0200);
    s_arready = 1;
    #1;
    chk("t2_arready", 32'({m0_arready, m1_arready}), 32'b01);
    tick();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hAAAA_0001; m1_rready = 1;
    exp_r1_q.push_back(32'hAAAA_0001);
    #1;
    chk("t2_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'b01);
    tick();
    s_rvalid = 0; m1_rready = 0;
    #1;
    chk("t2_gap_idle", 32'(rd_state), 32'd0);
    tick();
    chk("t2_then_gnt0", 32'(rd_state), 32'd1);
    s_arready = 1;
    tick();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hBBBB_0002; m0_rready = 1;
    exp_r0_q.push_back(32'hBBBB_0002);
    tick();
    s_rvalid = 0; m0_rready = 0;
    #1;
    chk("t2_end_idle", 32'(rd_state), 32'd0);

    // M1: W first, AW three cycles later, AW ready delayed; grant held until B
    do_reset();
    aw0 = aw_hs; w0 = w_hs;
    m1_wvalid = 1; m1_wdata = 32'hCAFE_0003; m1_wstrb = 4'h3; s_wready = 1;
    exp_w_q.push_back(32'hCAFE_0003);
    #1;
    chk("t3_idle", 32'({wr_state, s_wvalid}), 32'd0);
    tick();
    chk("t3_gnt1", 32'(wr_state), 32'd2);
    chk("t3_w_only", 32'({s_wvalid, s_awvalid, m1_wready}), 32'b101);
    chk("t3_wstrb", 32'(s_wstrb), 32'h3);
    tick();
    chk("t3_w_masked", 32'({s_wvalid, m1_wready}), 32'd0);
    m1_wvalid = 0; s_wready = 0;
    tick();
    tick();
    m1_awvalid = 1; m1_awaddr = 32'h0000_0044; m1_awprot = 3'b101;
    exp_aw_q.push_back(32'h0000_0044);
    #1;
    chk("t3_aw_fwd", 32'({s_awvalid, m1_awready}), 32'b10);
    chk("t3_awprot", 32'(s_awprot), 32'd5);
    tick();
    tick();
    s_awready = 1;
    #1;
    chk("t3_awready", 32'(m1_awready), 32'd1);
    tick();
    m1_awvalid = 0; s_awready = 0;
    m0_awvalid = 1; m0_awaddr = 32'h0000_0099;
    #1;
    chk("t3_aw_hs_once", 32'(aw_hs - aw0), 32'd1);
    chk("t3_w_hs_once", 32'(w_hs - w0), 32'd1);
    chk("t3_m0_waits", 32'({s_awvalid, m0_awready}), 32'd0);
    tick();
    tick();
    chk("t3_held", 32'(wr_state), 32'd2);
    s_bvalid = 1; s_bresp = 2'b10; m1_bready = 1;
    #1;
    chk("t3_bvalid", 32'({m0_bvalid, m1_bvalid}), 32'b01);
    chk("t3_bresp_bcast", 32'({m0_bresp, m1_bresp}), 32'b1010);
    tick();
    s_bvalid = 0; m1_bready = 0;
    #1;
    chk("t3_gap_idle", 32'({wr_state, s_awvalid}), 32'd0);
    tick();
    chk("t3_m0_next", 32'(wr_state), 32'd1);

    // M0 holds write grant while M1 reads
    do_reset();
    m0_awvalid = 1; m0_awaddr = 32'h0000_0020; m0_wvalid = 1; m0_wdata = 32'h0000_0055;
    tick();
    m1_arvalid = 1; m1_araddr = 32'h0000_0100;
    exp_ar_q.push_back(32'h0000_0100);
    tick();
    chk("t4_concurrent", 32'({wr_state, rd_state}), 32'b0110);
    s_arready = 1;
    tick();
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h1234_5678; m1_rready = 1;
    exp_r1_q.push_back(32'h1234_5678);
    #1;
    chk("t4_m1_rdata", m1_rdata, 32'h1234_5678);
    tick();
    s_rvalid = 0; m1_rready = 0;
    #1;
    chk("t4_rd_done_wr_held", 32'({wr_state, rd_state}), 32'b0100);

    // reset while GNT0 waits on B
    s_awready = 1; s_wready = 1;
    exp_aw_q.push_back(32'h0000_0020); exp_w_q.push_back(32'h0000_0055);
    tick();
    m0_awvalid = 0; m0_wvalid = 0; s_awready = 0; s_wready = 0;
    s_bvalid = 1;
    #1;
    chk("t5_pending_b", 32'({m0_bvalid, s_bready}), 32'b10);
    nrst = 1'b0;
    #1;
    chk("t5_rst_valids", 32'({m0_bvalid, s_awvalid, s_wvalid, s_bready}), 32'd0);
    chk("t5_rst_idle", 32'(wr_state), 32'd0);
    tick();
    idle_inputs();
    nrst = 1'b1;
    m1_awvalid = 1; m1_awaddr = 32'h0000_0080;
    exp_aw_q.push_back(32'h0000_0080);
    tick();
    chk("t5_m1_gnt", 32'({wr_state, s_awvalid}), 32'b101);
    s_awready = 1;
    tick();
    m1_awvalid = 0; s_awready = 0;

    // M0 stalls R for four cycles; M1 read waits
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h0000_0400;
    exp_ar_q.push_back(32'h0000_0400);
    tick();
    s_arready = 1;
    tick();
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h0BAD_F00D; m1_arvalid = 1; m1_araddr = 32'h0000_0500;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_stall", 32'({rd_state, s_rready, s_arvalid, m1_arready, m1_rvalid}), 32'b010000);
      tick();
    end
    m0_rready = 1;
    exp_r0_q.push_back(32'h0BAD_F00D);
    #1;
    chk("t6_rready", 32'({s_rready, m0_rvalid}), 32'b11);
    tick();
    m0_rready = 0; s_rvalid = 0;
    #1;
    chk("t6_idle", 32'(rd_state), 32'd0);
    tick();
    chk("t6_m1_next", 32'({rd_state, s_araddr}), {2'b10, 32'h0000_0500});

    chk("sb_drained", 32'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()
                          + exp_r0_q.size() + exp_r1_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
